// File: rtl/press_classifier.sv
// Button gesture classifier: short, long and double presses timed in ticks.
// Define AUTOREPEAT_EN to emit repeat_press pulses while held after a long press.
module press_classifier #(
  parameter int LONG_TICKS   = 50,
  parameter int DOUBLE_TICKS = 15,
  parameter int REPEAT_TICKS = 10,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic debounced,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_press,
  output logic held
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_WAIT2,
    S_PRESS2,
    S_LONG,
    S_WAITREL
  } state_t;

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (LONG_TICKS < 1 || LONG_TICKS > CNT_MAX) begin : g_bad_long
    $error("LONG_TICKS out of range");
  end
  if (DOUBLE_TICKS < 1 || DOUBLE_TICKS > CNT_MAX) begin : g_bad_dbl
    $error("DOUBLE_TICKS out of range");
  end
  if (REPEAT_TICKS < 1 || REPEAT_TICKS > CNT_MAX) begin : g_bad_rep
    $error("REPEAT_TICKS out of range");
  end

  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_M1  = CNT_W'(DOUBLE_TICKS - 1);
`ifdef AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_TICKS - 1);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic short_q, short_d;
  logic long_q, long_d;
  logic dbl_q, dbl_d;
  logic rep_q, rep_d;
  logic held_q, held_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Level changes are tested before tick, so a coincident tick is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    rep_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (debounced) state_d = S_PRESS1;
      end
      S_PRESS1: begin
        if (!debounced) begin
          state_d = S_WAIT2;
        end else if (tick) begin
          if (cnt_q == LONG_M1) begin
            long_d  = 1'b1;
            state_d = S_LONG;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_WAIT2: begin
        if (debounced) begin
          state_d = S_PRESS2;
        end else if (tick) begin
          if (cnt_q == DBL_M1) begin
            short_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_PRESS2: begin
        if (!debounced) begin
          dbl_d   = 1'b1;
          state_d = S_IDLE;
        end else if (tick) begin
          if (cnt_q == LONG_M1) begin
            dbl_d   = 1'b1;
            state_d = S_WAITREL;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_LONG: begin
        if (!debounced) begin
          state_d = S_IDLE;
`ifdef AUTOREPEAT_EN
        end else if (tick) begin
          if (cnt_q == REP_M1) begin
            rep_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
`endif
        end
      end
      S_WAITREL: begin
        if (!debounced) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    held_d = (state_d == S_LONG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = dbl_q;
  assign repeat_press = rep_q;
  assign held         = held_q;

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier; gesture model scans whole input
// waveforms phase by phase, with a reset between phases.
module tb_press_classifier;

  localparam int LT = 4;
  localparam int DT = 3;
  localparam int RT = 2;

  localparam int K_SHORT = 1;
  localparam int K_LONG  = 2;
  localparam int K_DBL   = 3;
  localparam int K_REP   = 4;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic debounced = 1'b0;
  logic short_press, long_press, double_press;
  logic repeat_press, held;

  press_classifier #(
    .LONG_TICKS(LT),
    .DOUBLE_TICKS(DT),
    .REPEAT_TICKS(RT),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .debounced(debounced),
    .short_press(short_press),
    .long_press(long_press),
    .double_press(double_press),
    .repeat_press(repeat_press),
    .held(held)
  );

  always #5 clk = ~clk;

  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  cyc = 0;
  bit  held_exp [0:65535];
  ev_t exp_q[$];
  bit  db_q[$];
  bit  tk_q[$];

  function automatic void chk(bit ok, string name, int act, int exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void push(int c, int kind);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    exp_q.push_back(e);
  endfunction

  // Gesture-level reference: walk the press/release runs, counting ticks.
  task automatic model(int base);
    int n, c, k, m, h;
    bit lng;
    n = db_q.size();
    c = 0;
    while (c < n) begin
      if (!db_q[c]) begin
        c++;
        continue;
      end
      k = c + 1;
      m = 0;
      lng = 0;
      while (k < n && db_q[k]) begin
        if (tk_q[k]) begin
          m++;
          if (m == LT) begin
            lng = 1;
            break;
          end
        end
        k++;
      end
      if (k >= n) break;
      if (lng) begin
        push(base + k, K_LONG);
        h = k;
        m = 0;
        k++;
        while (k < n && db_q[k]) begin
`ifdef AUTOREPEAT_EN
          if (tk_q[k]) begin
            m++;
            if (m == RT) begin
              push(base + k, K_REP);
              m = 0;
            end
          end
`endif
          k++;
        end
        for (int j = h; j < k; j++) held_exp[base + j] = 1'b1;
        c = k + 1;
        continue;
      end
      k++;
      m = 0;
      while (k < n && !db_q[k]) begin
        if (tk_q[k]) begin
          m++;
          if (m == DT) break;
        end
        k++;
      end
      if (k >= n) break;
      if (!db_q[k]) begin
        push(base + k, K_SHORT);
        c = k + 1;
        continue;
      end
      k++;
      m = 0;
      while (k < n && db_q[k]) begin
        if (tk_q[k]) begin
          m++;
          if (m == LT) break;
        end
        k++;
      end
      if (k >= n) break;
      push(base + k, K_DBL);
      if (db_q[k]) begin
        k++;
        while (k < n && db_q[k]) k++;
      end
      c = k + 1;
    end
  endtask

  task automatic add_run(bit lvl, int len);
    repeat (len) db_q.push_back(lvl);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk({short_press, long_press, double_press, repeat_press, held} == 5'b0,
        "reset_outputs",
        int'({short_press, long_press, double_press, repeat_press, held}), 0);
  endtask

  task automatic run_phase(int off);
    int base;
    do_reset();
    tk_q.delete();
    for (int i = 0; i < db_q.size(); i++) tk_q.push_back(((i + off) % 4) == 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    model(base);
    for (int i = 0; i < db_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      debounced = db_q[i];
      tick      = tk_q[i];
    end
    db_q.delete();
  endtask

  task automatic rand_phase();
    int n, mx;
    bit lvl;
    n = $urandom_range(40, 160);
    mx = ($urandom_range(0, 2) == 0) ? 6 : (($urandom_range(0, 1) == 0) ? 14 : 40);
    lvl = 1'b0;
    while (db_q.size() < n) begin
      add_run(lvl, $urandom_range(1, mx));
      lvl = ~lvl;
    end
    run_phase($urandom_range(0, 3));
  endtask

  // Monitor: pulses pop the scoreboard, held is checked every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        int kind;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          chk(1'b0, "missing_pulse", 0, exp_q[0].kind);
          void'(exp_q.pop_front());
        end
        kind = short_press ? K_SHORT : long_press ? K_LONG :
               double_press ? K_DBL : repeat_press ? K_REP : 0;
        chk($countones({short_press, long_press, double_press, repeat_press}) <= 1,
            "pulse_onehot",
            $countones({short_press, long_press, double_press, repeat_press}), 1);
        if (kind != 0) begin
          if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            chk(kind == exp_q[0].kind, "pulse_kind", kind, exp_q[0].kind);
            void'(exp_q.pop_front());
          end else begin
            chk(1'b0, "unexpected_pulse", kind, 0);
          end
        end
        chk(held == held_exp[cyc], "held", int'(held), int'(held_exp[cyc]));
      end
      cyc++;
    end
  end

  initial begin
    // Short: 2 ticks pressed, then 3 released.
    add_run(1, 8); add_run(0, 20);
    run_phase(1);
    // Long: held across 4 ticks, then release.
    add_run(1, 24); add_run(0, 8);
    run_phase(1);
    // Double: re-press within one tick.
    add_run(1, 6); add_run(0, 3); add_run(1, 6); add_run(0, 16);
    run_phase(1);
    // Long hold for 10+ ticks.
    add_run(1, 44); add_run(0, 4);
    run_phase(1);
    // Release coincides with the 4th tick.
    add_run(1, 15); add_run(0, 20);
    run_phase(1);
    // Double whose second press reaches the long threshold.
    add_run(1, 5); add_run(0, 4); add_run(1, 30); add_run(0, 6);
    run_phase(2);
    // Reset mid-press with the button still down, then resume.
    add_run(0, 2); add_run(1, 7);
    run_phase(1);
    add_run(1, 20); add_run(0, 16);
    run_phase(1);
    for (int p = 0; p < 40; p++) rand_phase();
    do_reset();
    repeat (2) @(negedge clk);
    chk(exp_q.size() == 0, "leftover_expected", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
